// File: rtl/ber_if.sv
// ber_if: sample/reference inputs and BER status outputs of the ber_checker.
interface ber_if #(
    parameter int NB_DATA  = 8,
    parameter int NB_PHASE = 2,
    parameter int NB_DLY   = 9,
    parameter int NB_CNT   = 32
);
    logic                i_enable;
    logic [NB_DATA-1:0]  i_data;
    logic                i_ref_bit;
    logic                i_ref_valid;
    logic [NB_PHASE-1:0] i_phase;
    logic                i_clear;
    logic                o_rx_bit;
    logic                o_rx_valid;
    logic                o_sync;
    logic [NB_DLY-1:0]   o_delay;
    logic [NB_CNT-1:0]   o_err_count;
    logic [NB_CNT-1:0]   o_bit_count;
    modport master (
        output i_enable, i_data, i_ref_bit, i_ref_valid, i_phase, i_clear,
        input  o_rx_bit, o_rx_valid, o_sync, o_delay, o_err_count, o_bit_count
    );
    modport slave (
        input  i_enable, i_data, i_ref_bit, i_ref_valid, i_phase, i_clear,
        output o_rx_bit, o_rx_valid, o_sync, o_delay, o_err_count, o_bit_count
    );
endinterface

// File: rtl/ber_checker.sv
// ber_checker: decimate/slice the oversampled stream, search the reference delay, then count bit errors.
module ber_checker #(
    parameter int NB_DATA    = 8,
    parameter int N_PHASE    = 4,
    parameter int NB_PHASE   = 2,
    parameter int N_DLY      = 512,
    parameter int NB_DLY     = 9,
    parameter int SEARCH_LEN = 64,
    parameter int NB_CNT     = 32
) (
    input logic clock,
    input logic i_reset,
    ber_if.slave bus
);
    localparam int NB_WIN = $clog2(SEARCH_LEN + 1);
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t              state_q, state_d;
    logic [NB_PHASE-1:0] ph_q, ph_d;
    logic [N_DLY-1:0]    ref_q, ref_d;
    logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d, win_err_q, win_err_d;
    logic [NB_DLY-1:0]   delay_q, delay_d;
    logic [NB_CNT-1:0]   err_q, err_d, bits_q, bits_d;
    logic                rx_bit_q, rx_bit_d, rx_valid_q, rx_valid_d;
    logic                samp, bit_s, mism, win_end;

    always_comb begin
        samp       = ph_q == bus.i_phase;
        bit_s      = bus.i_data[NB_DATA-1];
        mism       = bit_s ^ ref_q[delay_q];
        win_end    = win_cnt_q == NB_WIN'(SEARCH_LEN - 1);
        ph_d       = ph_q == NB_PHASE'(N_PHASE - 1) ? '0 : ph_q + 1'b1;
        ref_d      = bus.i_ref_valid ? {ref_q[N_DLY-2:0], bus.i_ref_bit} : ref_q;
        rx_valid_d = samp;
        rx_bit_d   = samp ? bit_s : rx_bit_q;
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        delay_d    = delay_q;
        err_d      = err_q;
        bits_d     = bits_q;
        if (bus.i_clear) begin
            state_d   = SEARCH;
            win_cnt_d = '0;
            win_err_d = '0;
            delay_d   = '0;
            err_d     = '0;
            bits_d    = '0;
        end else if (samp && state_q == SEARCH) begin
            win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
            win_err_d = win_end ? '0 : win_err_q + NB_WIN'(mism);
            // A window locks only if no sample in it, including the last, mismatched
            if (win_end && win_err_q == '0 && !mism)
                state_d = LOCKED;
            else if (win_end)
                delay_d = delay_q == NB_DLY'(N_DLY - 1) ? '0 : delay_q + 1'b1;
        end else if (samp) begin
            bits_d = &bits_q ? bits_q : bits_q + 1'b1;
            err_d  = (mism && !(&err_q)) ? err_q + 1'b1 : err_q;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= SEARCH;
            ph_q       <= '0;
            ref_q      <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            delay_q    <= '0;
            err_q      <= '0;
            bits_q     <= '0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else if (bus.i_enable) begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            ref_q      <= ref_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            delay_q    <= delay_d;
            err_q      <= err_d;
            bits_q     <= bits_d;
            rx_bit_q   <= rx_bit_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.o_rx_bit    = rx_bit_q;
    assign bus.o_rx_valid  = rx_valid_q;
    assign bus.o_sync      = state_q == LOCKED;
    assign bus.o_delay     = delay_q;
    assign bus.o_err_count = err_q;
    assign bus.o_bit_count = bits_q;
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: directed vectors for slicing, delay search/lock, error counting, clear, saturation and wrap.
module tb_ber_checker;
    logic clock = 1'b0;
    logic i_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic r [6000];

    always #5 clock = ~clock;

    ber_if #(.NB_DATA(8), .NB_PHASE(2), .NB_DLY(9), .NB_CNT(32)) bus ();
    ber_if #(.NB_DATA(8), .NB_PHASE(2), .NB_DLY(3), .NB_CNT(4)) bus2 ();

    ber_checker dut (.clock(clock), .i_reset(i_reset), .bus(bus));
    ber_checker #(.N_DLY(8), .NB_DLY(3), .SEARCH_LEN(4), .NB_CNT(4)) dut2 (
        .clock(clock), .i_reset(i_reset), .bus(bus2));

    typedef struct {
        logic [7:0] data;
        logic       exp_valid;
        logic       exp_bit;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic rv, input logic rb, input logic clr);
        bus.i_enable = 1'b1;
        bus.i_data = d;
        bus.i_ref_valid = rv;
        bus.i_ref_bit = rb;
        bus.i_clear = clr;
        @(posedge clock);
        #1;
    endtask

    // One symbol: reference bit on phase 0, received bit delayed by 37 symbols
    task automatic sym(input int s, input logic flip, input logic clr);
        logic       b;
        logic [7:0] d;
        b = s >= 37 ? r[s-37] : 1'b0;
        d = b ? 8'hC0 : 8'h40;
        if (flip) d = -d;
        step(d, 1'b1, r[s], clr);
        for (int k = 1; k < 4; k++) step(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sym2(input logic [7:0] d);
        bus2.i_enable = 1'b1;
        bus2.i_data = d;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
        end
        bus2.i_enable = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rxb"}, 32'(bus.o_rx_bit), 0);
        chk({name, "_rxv"}, 32'(bus.o_rx_valid), 0);
        chk({name, "_sync"}, 32'(bus.o_sync), 0);
        chk({name, "_dly"}, 32'(bus.o_delay), 0);
        chk({name, "_err"}, bus.o_err_count, 0);
        chk({name, "_bits"}, bus.o_bit_count, 0);
        chk({name, "_sync2"}, 32'(bus2.o_sync), 0);
        chk({name, "_bits2"}, 32'(bus2.o_bit_count), 0);
    endtask

    task automatic do_reset();
        bus.i_enable = 1'b0;
        bus2.i_enable = 1'b0;
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        vec_t       tbl [8];
        logic [8:0] lfsr;
        int         s;
        lfsr = 9'h1FF;
        for (int i = 0; i < 6000; i++) begin
            r[i] = lfsr[8];
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
        tbl[0] = '{8'd10, 1'b0, 1'b0};
        tbl[1] = '{8'd20, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1};
        tbl[3] = '{8'd30, 1'b0, 1'b1};
        tbl[4] = '{8'd10, 1'b0, 1'b1};
        tbl[5] = '{8'd20, 1'b0, 1'b1};
        tbl[6] = '{8'hFF, 1'b1, 1'b1};
        tbl[7] = '{8'd30, 1'b0, 1'b1};
        bus2.i_phase = 2'd0;
        bus2.i_ref_valid = 1'b0;
        bus2.i_ref_bit = 1'b0;
        bus2.i_clear = 1'b0;
        bus2.i_data = 8'h00;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            bus.i_enable = 1'($urandom);
            bus.i_data = 8'($urandom);
            bus.i_ref_bit = 1'($urandom);
            bus.i_ref_valid = 1'($urandom);
            bus.i_phase = 2'($urandom);
            bus.i_clear = 1'($urandom);
            bus2.i_enable = 1'($urandom);
            bus2.i_data = 8'($urandom);
            @(posedge clock);
            #1;
            chk_zero("reset");
        end
        bus.i_enable = 1'b0;
        bus2.i_enable = 1'b0;
        i_reset = 1'b0;
        @(posedge clock);
        #1;
        chk_zero("post_reset");

        // Phase select: only phase 2 carries a negative sample
        bus.i_phase = 2'd2;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].data, 1'b0, 1'b0, 1'b0);
            chk($sformatf("phase_valid%0d", i), 32'(bus.o_rx_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("phase_bit%0d", i), 32'(bus.o_rx_bit), 32'(tbl[i].exp_bit));
        end

        // Loopback search and lock at delay 37
        do_reset();
        s = 0;
        for (int i = 0; i < 64; i++) begin sym(s, 1'b0, 1'b0); s++; end
        chk("search_dly1", 32'(bus.o_delay), 1);
        chk("search_bits", bus.o_bit_count, 0);
        while (s < 38 * 64 - 1) begin sym(s, 1'b0, 1'b0); s++; end
        chk("pre_lock_sync", 32'(bus.o_sync), 0);
        chk("pre_lock_dly", 32'(bus.o_delay), 37);
        sym(s, 1'b0, 1'b0); s++;
        chk("lock_sync", 32'(bus.o_sync), 1);
        chk("lock_dly", 32'(bus.o_delay), 37);
        chk("lock_bits", bus.o_bit_count, 0);
        for (int i = 0; i < 100; i++) begin sym(s, 1'b0, 1'b0); s++; end
        chk("locked_bits", bus.o_bit_count, 100);
        chk("locked_err", bus.o_err_count, 0);

        // Error injection at three separated symbols
        for (int i = 0; i < 100; i++) begin sym(s, i == 10 || i == 40 || i == 70, 1'b0); s++; end
        chk("inj_err", bus.o_err_count, 3);
        chk("inj_bits", bus.o_bit_count, 200);

        // Freeze, then clear and relock
        bus.i_enable = 1'b0;
        bus.i_data = 8'hC0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            chk("freeze_rxv", 32'(bus.o_rx_valid), 0);
        end
        chk("freeze_bits", bus.o_bit_count, 200);
        chk("freeze_err", bus.o_err_count, 3);
        chk("freeze_sync", 32'(bus.o_sync), 1);
        sym(s, 1'b0, 1'b1); s++;
        chk("clear_sync", 32'(bus.o_sync), 0);
        chk("clear_dly", 32'(bus.o_delay), 0);
        chk("clear_err", bus.o_err_count, 0);
        chk("clear_bits", bus.o_bit_count, 0);
        for (int i = 0; i < 38 * 64 - 1; i++) begin sym(s, 1'b0, 1'b0); s++; end
        chk("relock_sync", 32'(bus.o_sync), 1);
        chk("relock_dly", 32'(bus.o_delay), 37);
        bus.i_enable = 1'b0;

        // Small instance: delay wrap, then lock and saturate on all-error data
        for (int i = 0; i < 28; i++) sym2(8'hC0);
        chk("wrap_dly7", 32'(bus2.o_delay), 7);
        for (int i = 0; i < 4; i++) sym2(8'hC0);
        chk("wrap_dly0", 32'(bus2.o_delay), 0);
        chk("wrap_sync", 32'(bus2.o_sync), 0);
        for (int i = 0; i < 4; i++) sym2(8'h40);
        chk("sat_lock", 32'(bus2.o_sync), 1);
        for (int i = 0; i < 14; i++) sym2(8'hC0);
        chk("sat_err14", 32'(bus2.o_err_count), 14);
        chk("sat_bits14", 32'(bus2.o_bit_count), 14);
        for (int i = 0; i < 6; i++) sym2(8'hC0);
        chk("sat_err15", 32'(bus2.o_err_count), 15);
        chk("sat_bits15", 32'(bus2.o_bit_count), 15);

        // Async reset mid-lock, no clock edge needed
        i_reset = 1'b1;
        #1;
        chk_zero("async_reset");
        i_reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
